// File: rtl/adapter_pkg.sv
// Shared types, transfer-length table and length lookup for the output stream adapter.
package adapter_pkg;

  localparam int MAX_LEN = 932;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    MODE_KEYGEN   = 2'd0,
    MODE_VERIFY   = 2'd1,
    MODE_SIGN     = 2'd2,
    MODE_SIGN_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_KEYGEN_L2 = LEN_W'(480);
  localparam logic [LEN_W-1:0] LEN_KEYGEN_L3 = LEN_W'(744);
  localparam logic [LEN_W-1:0] LEN_KEYGEN_L5 = LEN_W'(932);
  localparam logic [LEN_W-1:0] LEN_VERIFY    = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_SIGN_L2   = LEN_W'(303);
  localparam logic [LEN_W-1:0] LEN_SIGN_L3   = LEN_W'(412);
  localparam logic [LEN_W-1:0] LEN_SIGN_L5   = LEN_W'(575);

  // Any security level other than 2 or 3 selects the level-5 length.
  function automatic logic [LEN_W-1:0] out_len(input mode_e mode, input logic [2:0] sec_lvl);
    logic [LEN_W-1:0] len;
    case (mode)
      MODE_KEYGEN: begin
        case (sec_lvl)
          3'd2:    len = LEN_KEYGEN_L2;
          3'd3:    len = LEN_KEYGEN_L3;
          default: len = LEN_KEYGEN_L5;
        endcase
      end
      MODE_VERIFY: len = LEN_VERIFY;
      default: begin
        case (sec_lvl)
          3'd2:    len = LEN_SIGN_L2;
          3'd3:    len = LEN_SIGN_L3;
          default: len = LEN_SIGN_L5;
        endcase
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; storage is a plain array read through the registered
// read pointer so it maps onto block RAM. DEPTH need not be a power of two.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      // Concurrent read and write keeps the occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_stream_adapter.sv
// Collects a fixed-length word stream from the core into a FIFO and replays it as an
// AXI-Stream transfer with TLAST on the final word and a done pulse afterwards.
module output_stream_adapter #(
  parameter int W       = 64,
  parameter int DEPTH   = 32,
  parameter int MAX_LEN = adapter_pkg::MAX_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [2:0]   sec_lvl,
  input  logic         core_valid_i,
  output logic         core_ready_o,
  input  logic [W-1:0] core_data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         done_o,
  output logic         err_o
);

  import adapter_pkg::*;

  localparam int CW = $clog2(MAX_LEN + 1);

  state_e        state;
  state_e        state_nx;
  logic [CW-1:0] len;
  logic [CW-1:0] len_m1;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          handshake;
  logic          final_in;
  logic          final_out;

  assign core_ready_o = (state == ST_FILL) && !fifo_full && !start;
  assign accept       = core_valid_i && core_ready_o;
  assign valid_o      = !fifo_empty;
  assign handshake    = valid_o && ready_i;
  assign len_m1       = len - CW'(1);
  assign final_in     = accept && (in_cnt == len_m1);
  assign final_out    = handshake && (out_cnt == len_m1) && (state == ST_DRAIN);
  assign last_o       = valid_o && (out_cnt == len_m1) && (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (start),
    .wr_en   (accept),
    .wr_data (core_data_i),
    .rd_en   (handshake),
    .rd_data (data_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_FILL;
    end else begin
      case (state)
        ST_FILL:  if (final_in)  state_nx = ST_DRAIN;
        ST_DRAIN: if (final_out) state_nx = ST_IDLE;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      err_o   <= 1'b0;
      done_o  <= 1'b0;
    end else if (start) begin
      len     <= CW'(out_len(mode_e'(mode), sec_lvl));
      in_cnt  <= '0;
      out_cnt <= '0;
      err_o   <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      if (accept && (in_cnt != len)) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (handshake && (out_cnt != len)) begin
        out_cnt <= out_cnt + 1'b1;
      end
      // Any word offered outside FILL is unexpected and latches the error.
      if (core_valid_i && (state != ST_FILL)) begin
        err_o <= 1'b1;
      end
      done_o <= final_out;
    end
  end

endmodule

// File: tb/tb_output_stream_adapter.sv
// Self-checking bench: a queue-based transfer model checked every cycle, plus directed scenarios.
module tb_output_stream_adapter;

  localparam int W     = 64;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [2:0]   sec_lvl;
  logic         core_valid_i;
  logic         core_ready_o;
  logic [W-1:0] core_data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         last_o;
  logic         done_o;
  logic         err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  output_stream_adapter #(.W(W), .DEPTH(DEPTH), .MAX_LEN(932)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .sec_lvl      (sec_lvl),
    .core_valid_i (core_valid_i),
    .core_ready_o (core_ready_o),
    .core_data_i  (core_data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer model ----------------
  logic [W-1:0] mq[$];
  int  m_len, m_in, m_out;
  bit  m_fill, m_busy, m_err, m_done, m_ok;
  bit  m_acc, m_hs, m_dn;

  function automatic int exp_len(input int md, input int sl);
    if (md == 1) return 1;
    if (md == 0) return (sl == 2) ? 480 : (sl == 3) ? 744 : 932;
    return (sl == 2) ? 303 : (sl == 3) ? 412 : 575;
  endfunction

  initial m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_len = 0; m_in = 0; m_out = 0;
      m_fill = 0; m_busy = 0; m_err = 0; m_done = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      m_acc = core_valid_i && m_fill && (mq.size() < DEPTH) && !start;
      m_hs  = (mq.size() > 0) && ready_i;
      m_dn  = 0;
      if (start) begin
        mq.delete();
        m_len = exp_len(int'(mode), int'(sec_lvl));
        m_in = 0; m_out = 0; m_err = 0;
        m_fill = 1; m_busy = 1;
      end else begin
        if (core_valid_i && !m_fill) m_err = 1;
        if (m_hs) begin
          void'(mq.pop_front());
          m_out++;
          if (m_out == m_len) begin
            m_busy = 0;
            m_dn = 1;
          end
        end
        if (m_acc) begin
          mq.push_back(core_data_i);
          m_in++;
          if (m_in == m_len) m_fill = 0;
        end
      end
      m_done = m_dn;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("core_ready", 64'(core_ready_o), 64'(m_fill && (mq.size() < DEPTH) && !start));
      check("valid", 64'(valid_o), 64'(mq.size() > 0));
      check("last", 64'(last_o), 64'((mq.size() > 0) && m_busy && (m_out == m_len - 1)));
      check("done", 64'(done_o), 64'(m_done));
      check("err", 64'(err_o), 64'(m_err));
      if (mq.size() > 0) check("data", data_o, mq[0]);
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] tag;
  int sent, got, last_cnt, done_cnt;

  task automatic do_start(input logic [1:0] md, input logic [2:0] sl, input logic [63:0] t);
    @(posedge clk); #1;
    start = 1'b1; mode = md; sec_lvl = sl;
    core_valid_i = 1'b0; ready_i = 1'b0;
    tag = t; sent = 0; got = 0; last_cnt = 0; done_cnt = 0;
  endtask

  task automatic stream(input int n_in, input int n_out, input int want_done,
                        input int vpct, input int rpct, input bit hold_valid, input int budget);
    int cyc = 0;
    while (!(sent >= n_in && got >= n_out && done_cnt >= want_done)) begin
      @(posedge clk); #1;
      start = 1'b0;
      core_valid_i = (sent < n_in) ? ($urandom_range(99) < vpct) : hold_valid;
      core_data_i  = tag + 64'(sent);
      ready_i      = ($urandom_range(99) < rpct);
      @(negedge clk); #1;
      if (core_valid_i && core_ready_o) sent++;
      if (valid_o && ready_i) begin
        check("order", data_o, tag + 64'(got));
        if (last_o) begin
          check("last_position", 64'(got), 64'(n_out - 1));
          last_cnt++;
        end
        got++;
      end
      if (done_o) done_cnt++;
      cyc++;
      if (cyc > budget) begin
        check("timeout", 64'(cyc), 64'(budget));
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; sec_lvl = 3'd0;
    core_valid_i = 1'b0; core_data_i = '0; ready_i = 1'b0;
    tag = '0; sent = 0; got = 0; last_cnt = 0; done_cnt = 0;

    // Reset, with start pressed at the same time: reset wins.
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_core_ready", 64'(core_ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);

    // Verify mode: single word 0xA5.
    do_start(2'd1, 3'd2, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; core_valid_i = 1'b1; core_data_i = 64'hA5; ready_i = 1'b0;
    @(negedge clk);
    check("v_core_ready", 64'(core_ready_o), 64'd1);
    @(posedge clk); #1 core_valid_i = 1'b0;
    @(negedge clk);
    check("v_valid", 64'(valid_o), 64'd1);
    check("v_last", 64'(last_o), 64'd1);
    check("v_data", data_o, 64'hA5);
    @(posedge clk); #1 ready_i = 1'b1;
    @(negedge clk);
    check("v_data_held", data_o, 64'hA5);
    @(posedge clk); #1 ready_i = 1'b0;
    @(negedge clk);
    check("v_done_pulse", 64'(done_o), 64'd1);
    check("v_valid_after", 64'(valid_o), 64'd0);
    idle_cycle();
    check("v_done_single", 64'(done_o), 64'd0);
    check("v_idle_ready", 64'(core_ready_o), 64'd0);

    // Sign, level 2, sink stalled: FIFO fills at DEPTH, then 303 words stream out.
    do_start(2'd2, 3'd2, 64'h1000_0000_0000_0000);
    stream(32, 0, 0, 100, 0, 1'b1, 200);
    check("s2_fill_accepted", 64'(sent), 64'd32);
    idle_cycle();
    idle_cycle();
    check("s2_ready_full", 64'(core_ready_o), 64'd0);
    check("s2_valid_full", 64'(valid_o), 64'd1);
    stream(303, 303, 1, 100, 100, 1'b0, 2000);
    check("s2_count", 64'(got), 64'd303);
    check("s2_last_count", 64'(last_cnt), 64'd1);
    check("s2_done_count", 64'(done_cnt), 64'd1);

    // Keygen, sec_lvl 5 (treated as level 5), random stalls on both sides.
    do_start(2'd0, 3'd5, 64'h2000_0000_0000_0000);
    stream(932, 932, 1, 60, 60, 1'b0, 20000);
    check("k5_count", 64'(got), 64'd932);
    check("k5_last_count", 64'(last_cnt), 64'd1);
    check("k5_done_count", 64'(done_cnt), 64'd1);
    repeat (3) idle_cycle();
    check("k5_no_extra_done", 64'(done_o), 64'd0);

    // Restart in the middle of draining a 480-word keygen transfer.
    do_start(2'd0, 3'd2, 64'h3000_0000_0000_0000);
    stream(480, 100, 0, 100, 50, 1'b0, 5000);
    do_start(2'd2, 3'd2, 64'h4000_0000_0000_0000);
    idle_cycle();
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_last", 64'(last_o), 64'd0);
    stream(303, 303, 1, 80, 70, 1'b0, 3000);
    check("flush_new_count", 64'(got), 64'd303);
    check("flush_new_done", 64'(done_cnt), 64'd1);

    // Sign level 3 with core_valid held high beyond word 412.
    do_start(2'd2, 3'd3, 64'h5000_0000_0000_0000);
    stream(412, 412, 1, 100, 100, 1'b1, 3000);
    check("e_count", 64'(got), 64'd412);
    check("e_err_set", 64'(err_o), 64'd1);
    idle_cycle();
    check("e_err_sticky", 64'(err_o), 64'd1);
    do_start(2'd0, 3'd3, 64'h6000_0000_0000_0000);
    idle_cycle();
    check("e_err_cleared", 64'(err_o), 64'd0);

    // Reset together with start while filling.
    stream(20, 0, 0, 100, 0, 1'b0, 100);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; core_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rs_core_ready", 64'(core_ready_o), 64'd0);
    check("rs_valid", 64'(valid_o), 64'd0);
    check("rs_last", 64'(last_o), 64'd0);
    check("rs_done", 64'(done_o), 64'd0);
    check("rs_err", 64'(err_o), 64'd0);
    repeat (2) idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
